// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the program ROM one byte per cycle, joins
// two-byte instructions (LDI8, JMP) into opcode + imm8, resolves JMP locally,
// stops at HLT and presents whole instructions to the decoder.
//
// Decoder handshake: instr_valid is high only in ISSUE. The payload
// (instr_opcode, instr_imm, instr_has_imm, instr_pc) is held stable while
// valid is high. A transfer happens on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is ignored in every other state.
module instr_fetch #(
  parameter int          ADDR_W   = 4,
  parameter int          DATA_W   = 8,
  parameter logic [3:0]  NIB_LDI8 = 4'hB,
  parameter logic [3:0]  NIB_JMP  = 4'hC,
  parameter logic [3:0]  NIB_HLT  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_has_imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;

  // Opcode class of the byte arriving from the ROM and of the held opcode.
  logic [3:0] rom_nib;
  logic [3:0] held_nib;
  logic       rom_two_byte;
  logic       accept;

  assign rom_nib      = rom_data[DATA_W-1:DATA_W-4];
  assign held_nib     = instr_opcode[DATA_W-1:DATA_W-4];
  assign rom_two_byte = (rom_nib == NIB_LDI8) || (rom_nib == NIB_JMP);
  assign accept       = (state == ISSUE) && instr_ready;

  // Next-state decode and ROM / handshake strobes.
  always_comb begin
    state_next  = state;
    rom_addr    = pc;
    rom_read_en = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH_OP: begin
        rom_read_en = 1'b1;
        state_next  = rom_two_byte ? FETCH_IMM : ISSUE;
      end
      FETCH_IMM: begin
        rom_read_en = 1'b1;
        rom_addr    = pc + ADDR_W'(1);
        state_next  = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = (held_nib == NIB_HLT) ? HALT : FETCH_OP;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH_OP;
      end
    endcase
    // The ROM is never enabled while reset is being applied.
    if (rst) begin
      rom_read_en = 1'b0;
    end
  end

  // State register; reset overrides any fetch or handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OP;
    end else begin
      state <= state_next;
    end
  end

  // Program counter and instruction payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      instr_opcode  <= '0;
      instr_imm     <= '0;
      instr_has_imm <= 1'b0;
      instr_pc      <= '0;
    end else begin
      case (state)
        FETCH_OP: begin
          instr_opcode  <= rom_data;
          instr_pc      <= pc;
          instr_imm     <= '0;
          instr_has_imm <= 1'b0;
        end
        FETCH_IMM: begin
          instr_imm     <= rom_data;
          instr_has_imm <= 1'b1;
        end
        ISSUE: begin
          // HLT leaves pc on its own address; only reset restarts fetch.
          if (accept && (held_nib != NIB_HLT)) begin
            if (held_nib == NIB_JMP) begin
              pc <= instr_imm[ADDR_W-1:0];
            end else begin
              pc <= pc + ADDR_W'(1) + ADDR_W'(instr_has_imm);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
